// File: rtl/counter.sv
// counter -- loadable up/down counter with a fixed step.
//
// Build option: define COUNTER_SATURATE_EN to clamp counting at the
// extremes (all-ones going up, zero going down) instead of wrapping.
// Loading is never clamped in either build.
//
// Parameters:
//   width_p      counter width in bits (1..32)
//   reset_val_p  value forced into the count while reset_ni is low
//   step_p       amount added/subtracted per enabled cycle
//
// Ports:
//   clk_i         rising-edge clock
//   reset_ni      asynchronous active-low reset
//   up_i          count-up enable
//   down_i        count-down enable (up_i == down_i means hold)
//   load_i        load enable, highest priority
//   loaded_val_i  value taken when load_i is high
//   counter_o     current count, straight from the register
//   step_o        constant step_p
//   reset_val_o   constant reset_val_p
module counter #(
  parameter int unsigned        width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0,
  parameter logic [width_p-1:0] step_p      = width_p'(1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               load_i,
  input  logic [width_p-1:0] loaded_val_i,
  output logic [width_p-1:0] counter_o,
  output logic [width_p-1:0] step_o,
  output logic [width_p-1:0] reset_val_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;
  logic [width_p-1:0] inc_val;
  logic [width_p-1:0] dec_val;

`ifdef COUNTER_SATURATE_EN
  // One extra bit exposes carry-out on add and borrow on subtract.
  logic [width_p:0] sum_w;
  logic [width_p:0] diff_w;

  always_comb begin
    sum_w   = {1'b0, count_q} + {1'b0, step_p};
    diff_w  = {1'b0, count_q} - {1'b0, step_p};
    inc_val = sum_w[width_p]  ? '1 : sum_w[width_p-1:0];
    dec_val = diff_w[width_p] ? '0 : diff_w[width_p-1:0];
  end
`else
  always_comb begin
    inc_val = count_q + step_p;
    dec_val = count_q - step_p;
  end
`endif

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loaded_val_i;
    end else if (up_i && !down_i) begin
      count_d = inc_val;
    end else if (down_i && !up_i) begin
      count_d = dec_val;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= reset_val_p;
    end else begin
      count_q <= count_d;
    end
  end

  assign counter_o   = count_q;
  assign step_o      = step_p;
  assign reset_val_o = reset_val_p;

endmodule

// File: tb/tb_counter.sv
// tb_counter -- directed self-checking bench for counter.
// Three instances share clock and reset:
//   A: width 10, reset 249, step 10
//   B: width 2,  reset 2,   step 1
//   C: width 4,  reset 7,   step 0 (up/down tied to B's enables)
// Expected values are queued when stimulus is driven and popped when
// the DUT output is sampled.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset_n;

  logic       a_up, a_down, a_load;
  logic [9:0] a_val, a_cnt, a_step, a_rv;

  logic       b_up, b_down, b_load;
  logic [1:0] b_val, b_cnt, b_step, b_rv;

  logic [3:0] c_cnt, c_step, c_rv;

  int unsigned tests;
  int unsigned fails;
  logic [31:0] exp_q[$];

  counter #(.width_p(10), .reset_val_p(10'd249), .step_p(10'd10)) u_a (
    .clk_i(clk), .reset_ni(reset_n), .up_i(a_up), .down_i(a_down),
    .load_i(a_load), .loaded_val_i(a_val), .counter_o(a_cnt),
    .step_o(a_step), .reset_val_o(a_rv)
  );

  counter #(.width_p(2), .reset_val_p(2'd2), .step_p(2'd1)) u_b (
    .clk_i(clk), .reset_ni(reset_n), .up_i(b_up), .down_i(b_down),
    .load_i(b_load), .loaded_val_i(b_val), .counter_o(b_cnt),
    .step_o(b_step), .reset_val_o(b_rv)
  );

  counter #(.width_p(4), .reset_val_p(4'd7), .step_p(4'd0)) u_c (
    .clk_i(clk), .reset_ni(reset_n), .up_i(b_up), .down_i(b_down),
    .load_i(1'b0), .loaded_val_i(4'd0), .counter_o(c_cnt),
    .step_o(c_step), .reset_val_o(c_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed=%0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic drv_a(input logic l, input logic [9:0] v, input logic u, input logic d);
    @(negedge clk);
    a_load = l; a_val = v; a_up = u; a_down = d;
  endtask

  task automatic drv_b(input logic l, input logic [1:0] v, input logic u, input logic d);
    @(negedge clk);
    b_load = l; b_val = v; b_up = u; b_down = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b1;
    a_up = 0; a_down = 0; a_load = 0; a_val = '0;
    b_up = 0; b_down = 0; b_load = 0; b_val = '0;

    // Asynchronous reset takes effect before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    push(249); check("a_reset_cnt", 32'(a_cnt));
    push(10);  check("a_step_o", 32'(a_step));
    push(249); check("a_reset_val_o", 32'(a_rv));
    push(2);   check("b_reset_cnt", 32'(b_cnt));
    push(1);   check("b_step_o", 32'(b_step));
    push(2);   check("b_reset_val_o", 32'(b_rv));
    push(7);   check("c_reset_cnt", 32'(c_cnt));

    // Enables asserted while in reset are ignored.
    drv_a(1, 10'd100, 1, 0);
    push(249); tick(); check("a_hold_in_reset", 32'(a_cnt));

    // Release between edges; first edge after release counts up.
    @(negedge clk);
    reset_n = 1'b1;
    a_load = 0; a_up = 1; a_down = 0;
    push(259); tick(); check("a_up_first_edge", 32'(a_cnt));

    drv_a(0, 10'd0, 0, 0);
    push(259); tick(); check("a_idle_hold", 32'(a_cnt));

    drv_a(0, 10'd0, 0, 1);
    push(249); tick(); check("a_down_1", 32'(a_cnt));
    push(239); tick(); check("a_down_2", 32'(a_cnt));

    drv_a(0, 10'd0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      push(239); tick(); check("a_up_down_hold", 32'(a_cnt));
    end

    drv_a(1, 10'd5, 1, 0);
    push(5); tick(); check("a_load_over_up", 32'(a_cnt));

    drv_a(1, 10'd1000, 0, 1);
    push(1000); tick(); check("a_load_over_down", 32'(a_cnt));

    drv_a(1, 10'd1020, 0, 0);
    push(1020); tick(); check("a_load_1020", 32'(a_cnt));
    drv_a(0, 10'd0, 1, 0);
    push(SAT ? 1023 : 6); tick(); check("a_up_overflow", 32'(a_cnt));

    drv_a(1, 10'd3, 0, 0);
    push(3); tick(); check("a_load_3", 32'(a_cnt));
    drv_a(0, 10'd0, 0, 1);
    push(SAT ? 0 : 1017); tick(); check("a_down_underflow", 32'(a_cnt));
    drv_a(0, 10'd0, 0, 0);

    // Narrow instance: wrap or clamp at the 2-bit limits.
    drv_b(0, 2'd0, 1, 0);
    push(3); push(7); tick(); check("b_up_1", 32'(b_cnt)); check("c_up_step0", 32'(c_cnt));
    push(SAT ? 3 : 0); tick(); check("b_up_2", 32'(b_cnt));
    drv_b(1, 2'd0, 0, 0);
    push(0); tick(); check("b_load_0", 32'(b_cnt));
    drv_b(0, 2'd0, 0, 1);
    push(SAT ? 0 : 3); push(7); tick(); check("b_down_from_0", 32'(b_cnt)); check("c_down_step0", 32'(c_cnt));
    drv_b(0, 2'd0, 0, 0);

    // Mid-cycle reset: count returns to reset value before the next edge.
    drv_a(1, 10'd77, 0, 0);
    push(77); tick(); check("a_load_77", 32'(a_cnt));
    drv_a(0, 10'd0, 1, 0);
    push(87); tick(); check("a_up_87", 32'(a_cnt));
    #2 reset_n = 1'b0;
    #1;
    push(249); check("a_async_reset_mid", 32'(a_cnt));
    a_load = 1; a_val = 10'd500;
    push(249); tick(); check("a_reset_held_edge", 32'(a_cnt));
    push(10);  check("a_step_o_in_reset", 32'(a_step));
    push(249); check("a_reset_val_o_in_reset", 32'(a_rv));
    @(negedge clk);
    reset_n = 1'b1;
    a_load = 0; a_up = 1;
    push(259); tick(); check("a_resume_after_reset", 32'(a_cnt));
    drv_a(0, 10'd0, 0, 0);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_drain: observed=%0d leftover, expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
